// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler: picks a ready slot plus a free FU and holds the issue until accepted.
// Define RS_AGE_ARB_EN to arbitrate by lowest tag; otherwise the lowest-index ready slot wins.
module rs_issue_scheduler #(
  parameter int NUM_SLOTS = 8,
  parameter int NUM_FU    = 4,
  parameter int TAG_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           alloc_valid,
  input  logic [TAG_WIDTH-1:0]           alloc_tag,
  output logic                           alloc_ready,
  output logic [$clog2(NUM_SLOTS)-1:0]   alloc_slot,
  input  logic [NUM_SLOTS-1:0]           slot_rdy,
  input  logic [NUM_FU-1:0]              fu_done,
  input  logic                           flush,
  output logic                           issue_valid,
  input  logic                           issue_ready,
  output logic [$clog2(NUM_SLOTS)-1:0]   issue_slot,
  output logic [$clog2(NUM_FU)-1:0]      issue_fu,
  output logic [TAG_WIDTH-1:0]           issue_tag,
  output logic [$clog2(NUM_SLOTS+1)-1:0] occ_count
);
  localparam int SW = $clog2(NUM_SLOTS);
  localparam int FW = $clog2(NUM_FU);
  localparam int CW = $clog2(NUM_SLOTS+1);

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [NUM_SLOTS-1:0]   occ_q, occ_d, pend_q, pend_d;
  logic [TAG_WIDTH-1:0]   tag_q [NUM_SLOTS];
  logic [TAG_WIDTH-1:0]   tag_d [NUM_SLOTS];
  logic [NUM_FU-1:0]      busy_q, busy_d;
  logic [SW-1:0]          issue_slot_q, issue_slot_d;
  logic [FW-1:0]          issue_fu_q, issue_fu_d;
  logic [TAG_WIDTH-1:0]   issue_tag_q, issue_tag_d;
  logic [CW-1:0]          occ_count_q, occ_count_d;

  logic [NUM_SLOTS-1:0]   cand;
  logic                   cand_found, take;
  logic [SW-1:0]          cand_idx;
  logic [TAG_WIDTH-1:0]   cand_tag;
  logic                   fu_found;
  logic [FW-1:0]          fu_idx;
  logic                   handshake, load;

  always_comb begin
    alloc_ready = |(~occ_q);
    alloc_slot  = '0;
    for (int i = NUM_SLOTS-1; i >= 0; i--) begin
      if (!occ_q[i]) alloc_slot = SW'(i);
    end
  end

  always_comb begin
    cand       = occ_q & slot_rdy & ~pend_q;
    cand_found = 1'b0;
    cand_idx   = '0;
    cand_tag   = '0;
    take       = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      take = cand[i] && !cand_found;
`ifdef RS_AGE_ARB_EN
      // Strict less-than keeps ties with the lower index already chosen.
      take = take || (cand[i] && cand_found && (tag_q[i] < cand_tag));
`endif
      if (take) begin
        cand_found = 1'b1;
        cand_idx   = SW'(i);
        cand_tag   = tag_q[i];
      end
    end
  end

  always_comb begin
    fu_found = 1'b0;
    fu_idx   = '0;
    for (int k = NUM_FU-1; k >= 0; k--) begin
      if (!busy_q[k]) begin
        fu_found = 1'b1;
        fu_idx   = FW'(k);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    occ_d        = occ_q;
    pend_d       = pend_q;
    tag_d        = tag_q;
    busy_d       = busy_q & ~fu_done;
    issue_slot_d = issue_slot_q;
    issue_fu_d   = issue_fu_q;
    issue_tag_d  = issue_tag_q;
    handshake    = (state_q == HOLD) && issue_ready;
    load         = ((state_q == EMPTY) || handshake) && cand_found && fu_found && !flush;
    if (flush) begin
      occ_d   = '0;
      pend_d  = '0;
      state_d = EMPTY;
    end else begin
      if (handshake) begin
        occ_d[issue_slot_q]  = 1'b0;
        pend_d[issue_slot_q] = 1'b0;
      end
      if (alloc_valid && alloc_ready) begin
        occ_d[alloc_slot]  = 1'b1;
        pend_d[alloc_slot] = 1'b0;
        tag_d[alloc_slot]  = alloc_tag;
      end
      if ((state_q == EMPTY) || handshake) begin
        if (load) begin
          pend_d[cand_idx] = 1'b1;
          busy_d[fu_idx]   = 1'b1;
          issue_slot_d     = cand_idx;
          issue_fu_d       = fu_idx;
          issue_tag_d      = cand_tag;
          state_d          = HOLD;
        end else begin
          state_d = EMPTY;
        end
      end
    end
    occ_count_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      occ_count_d = occ_count_d + CW'(occ_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      occ_q        <= '0;
      pend_q       <= '0;
      busy_q       <= '0;
      tag_q        <= '{default: '0};
      issue_slot_q <= '0;
      issue_fu_q   <= '0;
      issue_tag_q  <= '0;
      occ_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      occ_q        <= occ_d;
      pend_q       <= pend_d;
      busy_q       <= busy_d;
      tag_q        <= tag_d;
      issue_slot_q <= issue_slot_d;
      issue_fu_q   <= issue_fu_d;
      issue_tag_q  <= issue_tag_d;
      occ_count_q  <= occ_count_d;
    end
  end

  assign issue_valid = (state_q == HOLD);
  assign issue_slot  = issue_slot_q;
  assign issue_fu    = issue_fu_q;
  assign issue_tag   = issue_tag_q;
  assign occ_count   = occ_count_q;
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Bench for rs_issue_scheduler: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a behavioural model of the slot/FU bookkeeping.
`timescale 1ns/1ps
module tb_rs_issue_scheduler;
  localparam int NS = 8;
  localparam int NF = 4;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alloc_valid = 1'b0;
  logic [TW-1:0] alloc_tag = '0;
  logic          alloc_ready;
  logic [2:0]    alloc_slot;
  logic [NS-1:0] slot_rdy = '0;
  logic [NF-1:0] fu_done = '0;
  logic          flush = 1'b0;
  logic          issue_valid;
  logic          issue_ready = 1'b0;
  logic [2:0]    issue_slot;
  logic [1:0]    issue_fu;
  logic [TW-1:0] issue_tag;
  logic [3:0]    occ_count;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  rs_issue_scheduler #(.NUM_SLOTS(NS), .NUM_FU(NF), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .alloc_ready(alloc_ready), .alloc_slot(alloc_slot),
    .slot_rdy(slot_rdy), .fu_done(fu_done), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_slot(issue_slot),
    .issue_fu(issue_fu), .issue_tag(issue_tag), .occ_count(occ_count)
  );

  always #5 clk = ~clk;

  // Reference state: which slots hold work, which are already handed to the output, their tags,
  // which FUs are executing, and the instruction currently offered downstream.
  logic [NS-1:0] m_occ, m_pend;
  logic [TW-1:0] m_tag [NS];
  logic [NF-1:0] m_busy;
  bit            m_hold;
  int            m_slot, m_fu;
  logic [TW-1:0] m_itag;

`ifdef RS_AGE_ARB_EN
  int exp_tags  [3] = '{3, 5, 9};
  int exp_slots [3] = '{1, 0, 2};
`else
  int exp_tags  [3] = '{5, 3, 9};
  int exp_slots [3] = '{0, 1, 2};
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_zero(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) if (!v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_occ  = '0;
    m_pend = '0;
    m_busy = '0;
    for (int i = 0; i < NS; i++) m_tag[i] = '0;
    m_hold = 1'b0;
    m_slot = 0;
    m_fu   = 0;
    m_itag = '0;
  endtask

  task automatic model_step();
    int a, c, f;
    bit hs;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hs = m_hold && issue_ready;
    a  = lowest_zero(32'(m_occ), NS);
    f  = lowest_zero(32'(m_busy), NF);
    c  = -1;
    for (int i = 0; i < NS; i++) begin
      if (m_occ[i] && slot_rdy[i] && !m_pend[i]) begin
        if (c < 0) c = i;
`ifdef RS_AGE_ARB_EN
        else if (m_tag[i] < m_tag[c]) c = i;
`endif
      end
    end
    m_busy = m_busy & ~fu_done;
    if (flush) begin
      m_occ  = '0;
      m_pend = '0;
      m_hold = 1'b0;
      return;
    end
    if (hs) begin
      m_occ[m_slot]  = 1'b0;
      m_pend[m_slot] = 1'b0;
    end
    if (alloc_valid && a >= 0) begin
      m_occ[a]  = 1'b1;
      m_pend[a] = 1'b0;
      m_tag[a]  = alloc_tag;
    end
    if (!m_hold || hs) begin
      if (c >= 0 && f >= 0) begin
        m_pend[c] = 1'b1;
        m_busy[f] = 1'b1;
        m_slot    = c;
        m_fu      = f;
        m_itag    = m_tag[c];
        m_hold    = 1'b1;
      end else begin
        m_hold = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_issue_valid", 32'(issue_valid), 32'(m_hold));
      if (m_hold) begin
        chk("m_issue_slot", 32'(issue_slot), m_slot);
        chk("m_issue_fu", 32'(issue_fu), m_fu);
        chk("m_issue_tag", 32'(issue_tag), 32'(m_itag));
      end
      chk("m_alloc_ready", 32'(alloc_ready), 32'(!(&m_occ)));
      if (!(&m_occ)) chk("m_alloc_slot", 32'(alloc_slot), lowest_zero(32'(m_occ), NS));
      chk("m_occ_count", 32'(occ_count), $countones(m_occ));
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_issue_valid"}, 32'(issue_valid), 0);
    chk({pfx, "_issue_slot"}, 32'(issue_slot), 0);
    chk({pfx, "_issue_fu"}, 32'(issue_fu), 0);
    chk({pfx, "_issue_tag"}, 32'(issue_tag), 0);
    chk({pfx, "_occ_count"}, 32'(occ_count), 0);
    chk({pfx, "_alloc_ready"}, 32'(alloc_ready), 1);
    chk({pfx, "_alloc_slot"}, 32'(alloc_slot), 0);
  endtask

  initial begin
    model_reset();
    cmp_en = 1'b1;
    #2;
    chk_reset_outputs("rst");
    cyc();
    cyc();
    rst_n = 1'b1;

    // Three allocations, then all become ready together.
    alloc_valid = 1'b1; alloc_tag = 8'd5; cyc();
    alloc_tag = 8'd3; cyc();
    alloc_tag = 8'd9; cyc();
    alloc_valid = 1'b0; slot_rdy = 8'b0000_0111; issue_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("order_valid", 32'(issue_valid), 1);
      chk("order_tag", 32'(issue_tag), exp_tags[k]);
      chk("order_slot", 32'(issue_slot), exp_slots[k]);
      chk("order_fu", 32'(issue_fu), k);
    end
    cyc();
    chk("order_drain", 32'(issue_valid), 0);
    slot_rdy = '0;

    // Occupy FU 3 as well, so every FU is busy.
    alloc_valid = 1'b1; alloc_tag = 8'd20; cyc();
    alloc_valid = 1'b0; slot_rdy = 8'b1; cyc();
    chk("fu3_fu", 32'(issue_fu), 3);
    cyc();
    slot_rdy = '0;
    alloc_valid = 1'b1; alloc_tag = 8'd40; cyc();
    alloc_tag = 8'd41; cyc();
    alloc_valid = 1'b0; slot_rdy = 8'b11; issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("allbusy_valid", 32'(issue_valid), 0);
    end
    fu_done = 4'b0100; cyc();
    chk("done_edge_valid", 32'(issue_valid), 0);
    fu_done = 4'b0000; cyc();
    chk("fu2_valid", 32'(issue_valid), 1);
    chk("fu2_fu", 32'(issue_fu), 2);
    chk("fu2_tag", 32'(issue_tag), 40);

    // Stall with other FUs freed: payload must not move, nothing else may be taken.
    fu_done = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      cyc();
      fu_done = 4'b0000;
      chk("hold_valid", 32'(issue_valid), 1);
      chk("hold_slot", 32'(issue_slot), 0);
      chk("hold_fu", 32'(issue_fu), 2);
      chk("hold_tag", 32'(issue_tag), 40);
      chk("hold_alloc_ready", 32'(alloc_ready), 1);
    end
    issue_ready = 1'b1; cyc();
    chk("after_hold_tag", 32'(issue_tag), 41);
    chk("after_hold_fu", 32'(issue_fu), 0);
    chk("after_hold_slot", 32'(issue_slot), 1);
    cyc();
    chk("after_hold_drain", 32'(issue_valid), 0);
    slot_rdy = '0; issue_ready = 1'b0;

    // Fill every slot; the full-state alloc must be dropped.
    alloc_valid = 1'b1;
    for (int k = 0; k < NS; k++) begin
      alloc_tag = 8'(100 + k);
      cyc();
    end
    chk("full_alloc_ready", 32'(alloc_ready), 0);
    chk("full_occ_count", 32'(occ_count), 8);
    cyc();
    chk("full_ignored_count", 32'(occ_count), 8);
    alloc_valid = 1'b0; slot_rdy = 8'h10; cyc();
    chk("full_issue_slot", 32'(issue_slot), 4);
    chk("full_issue_fu", 32'(issue_fu), 1);
    chk("full_issue_tag", 32'(issue_tag), 104);
    slot_rdy = '0; issue_ready = 1'b1; alloc_valid = 1'b1; alloc_tag = 8'd77; cyc();
    chk("freed_alloc_ready", 32'(alloc_ready), 1);
    chk("freed_alloc_slot", 32'(alloc_slot), 4);
    chk("freed_occ_count", 32'(occ_count), 7);
    alloc_valid = 1'b0; issue_ready = 1'b0;

    // Flush while holding, with a competing alloc and handshake.
    fu_done = 4'b1111; cyc();
    fu_done = 4'b0000; slot_rdy = 8'h01; cyc();
    chk("pre_flush_fu", 32'(issue_fu), 0);
    flush = 1'b1; alloc_valid = 1'b1; alloc_tag = 8'd55; issue_ready = 1'b1; slot_rdy = '0; cyc();
    flush = 1'b0; alloc_valid = 1'b0; issue_ready = 1'b0;
    chk("flush_occ_count", 32'(occ_count), 0);
    chk("flush_valid", 32'(issue_valid), 0);
    chk("flush_alloc_slot", 32'(alloc_slot), 0);
    alloc_valid = 1'b1; alloc_tag = 8'd7; cyc();
    alloc_valid = 1'b0; slot_rdy = 8'h01; cyc();
    chk("post_flush_fu", 32'(issue_fu), 1);
    chk("post_flush_tag", 32'(issue_tag), 7);

    // Asynchronous reset in the middle of a held issue.
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_outputs("async_rst");
    slot_rdy = '0;
    cyc();
    cyc();
    rst_n = 1'b1;

    // Randomized traffic; small tag range forces tag ties.
    for (int n = 0; n < 3000; n++) begin
      if (!rst_n) rst_n = 1'b1;
      alloc_valid = 1'($urandom_range(0, 1));
      alloc_tag   = 8'($urandom_range(0, 15));
      slot_rdy    = 8'($urandom);
      fu_done     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      flush       = ($urandom_range(0, 40) == 0);
      issue_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 700) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end
      cyc();
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rs_issue_scheduler.md
RS_ISSUE_SCHEDULER -- requirements
Module: rs_issue_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 8, number of reservation slots (power of 2, >=2).
REQ-002 SHALL have parameter NUM_FU, default 4, number of functional units (power of 2, >=2).
REQ-003 SHALL have parameter TAG_WIDTH, default 8, width of the instruction tag.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port alloc_valid  in  1  request to place a new instruction into a slot.
REQ-007 SHALL have port alloc_tag  in  TAG_WIDTH  tag of the allocating instruction.
REQ-008 SHALL have port alloc_ready  out  1  at least one slot is free.
REQ-009 SHALL have port alloc_slot  out  clog2(NUM_SLOTS)  slot that receives the allocation.
REQ-010 SHALL have port slot_rdy  in  NUM_SLOTS  per-slot operands-ready flags from the slot array.
REQ-011 SHALL have port fu_done  in  NUM_FU  per-FU completion pulses.
REQ-012 SHALL have port flush  in  1  synchronous discard of all queued and pending work.
REQ-013 SHALL have port issue_valid  out  1  registered issue request.
REQ-014 SHALL have port issue_ready  in  1  downstream accepts the issue this cycle.
REQ-015 SHALL have ports issue_slot  out  clog2(NUM_SLOTS), issue_fu  out  clog2(NUM_FU) and issue_tag  out  TAG_WIDTH, which carry the issue payload.
REQ-016 SHALL have port occ_count  out  clog2(NUM_SLOTS+1)  number of occupied slots.

Function
REQ-017 SHALL keep per-slot registers occ, pend (selected but not yet handed off) and tag, plus per-FU register busy.
REQ-018 SHALL drive alloc_ready = OR of ~occ and alloc_slot = lowest-index free slot, both from registered state.
REQ-019 SHALL, on alloc_valid & alloc_ready, set occ, clear pend and store alloc_tag in alloc_slot; alloc_valid while !alloc_ready is ignored.
REQ-020 SHALL treat slot i as a candidate when occ[i] & slot_rdy[i] & ~pend[i].
REQ-021 SHALL select the candidate with the lowest unsigned tag, with ties going to the lower index; the free FU is the lowest-index FU with busy clear.
REQ-022 SHALL use a two-state output FSM: EMPTY (issue_valid=0) and HOLD (issue_valid=1).
REQ-023 SHALL, in EMPTY or on a HOLD handshake (issue_valid & issue_ready), load the payload when a candidate and a free FU both exist, setting pend and busy for them and entering or staying in HOLD; otherwise it enters EMPTY.
REQ-024 SHALL keep the payload stable in HOLD until the handshake occurs; on the handshake it SHALL clear occ and pend of issue_slot.
REQ-025 SHALL produce issue latency of 1 cycle: a candidate appearing in cycle N yields issue_valid in N+1.
REQ-026 SHALL clear busy[k] on fu_done[k] in the following cycle; fu_done on a non-busy FU is ignored; a same-cycle done and load never target the same FU.
REQ-027 SHALL make a slot freed by a handshake allocatable only from the next cycle.
REQ-028 SHALL make occ_count equal popcount(occ) as a registered value.
REQ-029 SHALL, on flush, clear all occ, pend and the output FSM to EMPTY; flush overrides alloc and handshake in the same cycle; busy is not cleared by flush.

Reset
REQ-030 SHALL, while rst_n=0, hold occ, pend and busy all 0, tags 0, FSM EMPTY, issue_valid=0, issue payload 0 and occ_count=0; alloc_ready=1 and alloc_slot=0.
REQ-031 SHALL, when reset is asserted mid-HOLD, drop the pending issue with no handshake.

Configuration
REQ-032 SHALL support macro RS_AGE_ARB_EN: when defined, the candidate is chosen by REQ-021; when undefined, the lowest-index candidate is chosen and tags are ignored for selection.

Verification
REQ-033 SHALL cover: allocate tags 5,3,9 into slots 0,1,2, set slot_rdy=3'b111 with all FUs free -> issue order tags 3,5,9 on FUs 0,1,2 (FIFO-index order 5,3,9 without RS_AGE_ARB_EN).
REQ-034 SHALL cover: issue_ready=0 for 4 cycles in HOLD -> payload constant, no second slot pended, alloc_ready unchanged.
REQ-035 SHALL cover: all 4 FUs busy with 2 ready slots -> issue_valid=0 until fu_done[2] pulses, then issue on FU 2 one cycle later.
REQ-036 SHALL cover: fill 8 slots -> alloc_ready=0 and occ_count=8; a handshake frees slot 4 -> next cycle alloc_ready=1, alloc_slot=4.
REQ-037 SHALL cover: flush during HOLD with a simultaneous alloc -> next cycle occ_count=0, issue_valid=0, busy FUs still busy until fu_done.
REQ-038 SHALL cover: rst_n low mid-HOLD -> all outputs at their REQ-030 values immediately, with no clock edge required.
